ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_scan_driver.sv | 76 +++++++
 tb/tb_ssd_scan_driver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed hex seven-segment scanner with registered outputs.
// Define SSD_LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module ssd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic [6:0]              seven_segments,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    scan_wrap
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_wrapped;
  logic                    w_adv;
  logic                    w_blank;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  assign w_adv = r_presc == P_LAST;
  assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
  assign w_blank = r_idx != '0 && (r_shadow >> {r_idx, 2'b00}) == '0;
`else
  assign w_blank = 1'b0;
`endif
  always_comb begin
    w_seg = 7'h7f;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'ha: w_seg = 7'b0001000;
      4'hb: w_seg = 7'b0000011;
      4'hc: w_seg = 7'b1000110;
      4'hd: w_seg = 7'b0100001;
      4'he: w_seg = 7'b0000110;
      4'hf: w_seg = 7'b0001110;
      default: w_seg = 7'h7f;
    endcase
  end
  // r_wrapped marks the edge idx returned to 0; scan_wrap re-times it to line up with the digit-0 outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc        <= '0;
      r_idx          <= '0;
      r_shadow       <= '0;
      r_wrapped      <= 1'b0;
      seven_segments <= 7'h7f;
      digit_sel      <= '1;
      scan_wrap      <= 1'b0;
    end else begin
      r_presc        <= w_adv ? '0 : r_presc + 1'b1;
      if (w_adv) r_idx <= r_idx == I_LAST ? '0 : r_idx + 1'b1;
      if (load) r_shadow <= value;
      r_wrapped      <= w_adv && r_idx == I_LAST;
      seven_segments <= w_blank ? 7'h7f : w_seg;
      digit_sel      <= ~(NUM_DIGITS'(1) << r_idx);
      scan_wrap      <= r_wrapped;
    end
  end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed bench with a cycle-count model for a 4-digit/div-4 and a 1-digit/div-1 scanner.
module tb_ssd_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load0 = 1'b0;
  logic        load1 = 1'b0;
  logic [15:0] value0 = '0;
  logic [3:0]  value1 = '0;
  logic [6:0]  seg0, seg1;
  logic [3:0]  sel0;
  logic [0:0]  sel1;
  logic        wrap0, wrap1;
  int          checks = 0;
  int          failures = 0;
  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'h7f;
`else
  localparam logic [6:0] ZB = 7'b1000000;
`endif
  always #5 clk = ~clk;
  ssd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) u0 (
    .clk(clk), .rst(rst), .value(value0), .load(load0),
    .seven_segments(seg0), .digit_sel(sel0), .scan_wrap(wrap0));
  ssd_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(1)) u1 (
    .clk(clk), .rst(rst), .value(value1), .load(load1),
    .seven_segments(seg1), .digit_sel(sel1), .scan_wrap(wrap1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // n = edges since reset release before this edge; returns {wrap, sel[7:0], seg[6:0]}
  function automatic logic [15:0] f_exp(int n, logic [31:0] sh, int nd, int sd);
    int d;
    logic [6:0] s;
    d = (n / sd) % nd;
    s = seg_tab[4'(sh >> (4 * d))];
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (d > 0 && (sh >> (4 * d)) == 0) s = 7'h7f;
`endif
    return {n >= 1 && n % (sd * nd) == 0, ~(8'd1 << d), s};
  endfunction
  int          n0, n1;
  logic [15:0] sh0;
  logic [3:0]  sh1;
  logic [15:0] e0, e1;
  bit          mv = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      n0  <= 0;
      n1  <= 0;
      sh0 <= '0;
      sh1 <= '0;
      e0  <= {1'b0, 8'hff, 7'h7f};
      e1  <= {1'b0, 8'hff, 7'h7f};
    end else begin
      e0  <= f_exp(n0, 32'(sh0), 4, 4);
      e1  <= f_exp(n1, 32'(sh1), 1, 1);
      sh0 <= load0 ? value0 : sh0;
      sh1 <= load1 ? value1 : sh1;
      n0  <= n0 + 1;
      n1  <= n1 + 1;
    end
    mv <= 1'b1;
  end
  always @(negedge clk) begin
    if (mv) begin
      chk("model_seg0", seg0, e0[6:0]);
      chk("model_sel0", sel0, e0[10:7]);
      chk("model_wrap0", wrap0, e0[15]);
      chk("model_seg1", seg1, e1[6:0]);
      chk("model_sel1", sel1, e1[7]);
      chk("model_wrap1", wrap1, e1[15]);
    end
  end
  task automatic wait_wrap();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wrap0 && k < 40);
    chk("wrap_seen", wrap0, 1'b1);
  endtask
  task automatic scan_check(input string nm, input logic [27:0] segs);
    logic [3:0] es;
    for (int i = 0; i < 16; i++) begin
      es = ~(4'd1 << (i / 4));
      chk({nm, "_sel"}, sel0, es);
      chk({nm, "_seg"}, seg0, segs[7*(i/4) +: 7]);
      chk({nm, "_wrap"}, wrap0, i == 0);
      @(negedge clk);
    end
  endtask
  task automatic load_val(input logic [15:0] v);
    load0 = 1'b1;
    value0 = v;
    @(negedge clk);
    load0 = 1'b0;
  endtask
  initial begin
    logic [3:0] es;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg0, 7'h7f);
    chk("rst_sel", sel0, 4'hf);
    chk("rst_wrap", wrap0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_sel", sel0, 4'b1110);
    chk("rel_seg", seg0, 7'b1000000);
    chk("n1_wrap_first", wrap1, 1'b0);
    chk("n1_seg_zero", seg1, 7'b1000000);
    load0 = 1'b1;
    value0 = 16'h1234;
    load1 = 1'b1;
    value1 = 4'h7;
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
    chk("n1_wrap", wrap1, 1'b1);
    chk("n1_sel", sel1, 1'b0);
    chk("n1_seg_old", seg1, 7'b1000000);
    @(negedge clk);
    chk("n1_seg7", seg1, 7'b1111000);
    wait_wrap();
    scan_check("s1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    load_val(16'hABCF);
    wait_wrap();
    scan_check("sabcf", {7'b0001000, 7'b0000011, 7'b1000110, 7'b0001110});
    load_val(16'h0050);
    wait_wrap();
    scan_check("s0050", {ZB, ZB, 7'b0010010, 7'b1000000});
    repeat (2) @(negedge clk);
    load0 = 1'b1;
    value0 = 16'h0009;
    @(negedge clk);
    load0 = 1'b0;
    chk("sim_old_sel", sel0, 4'b1110);
    chk("sim_old_seg", seg0, 7'b1000000);
    @(negedge clk);
    chk("sim_new_sel", sel0, 4'b1101);
    chk("sim_new_seg", seg0, ZB);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_sel", sel0, 4'hf);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      es = i < 4 ? 4'b1110 : 4'b1101;
      chk("restart_sel", sel0, es);
    end
    chk("restart_seg", seg0, ZB);
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
